// File: rtl/pipe_pkg.sv
// Shared types and defaults for the generic ready/valid pipeline register.
// The optional skid buffer is enabled by defining PIPE_SKID_EN.
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  // Control bundle bit positions: {is_zero, write_reg, mem_rd, mem_wr}
  localparam int CTRL_IS_ZERO   = 3;
  localparam int CTRL_WRITE_REG = 2;
  localparam int CTRL_MEM_RD    = 1;
  localparam int CTRL_MEM_WR    = 0;

  // All-zero control: a bubble that writes nothing and touches no memory
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Ready/valid bundle between two adjacent core stages, plus the stage flush.
// master = side driving the stage inputs, slave = the pipeline register itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Single-entry parking register used when the main register is full and stalled.
// Only instantiated when PIPE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (push) begin
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (push && !flush) begin
      data_q <= din;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic ready/valid pipeline register with flush and saturating stall counter.
// Define PIPE_SKID_EN for a 2-entry skid version with registered in_ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | no item held, out_valid=0
//   ST_FULL  | one item in main register, presented downstream
//   ST_SKID  | main register full and a second item parked (skid only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e       state;
  pipe_state_e       state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              out_valid_int;
  logic              in_ready_int;
  logic              in_xfer;
  logic              out_xfer;
  logic              load_in;

`ifdef PIPE_SKID_EN
  logic                     skid_valid;
  logic                     skid_push;
  logic                     skid_pop;
  logic [DATA_W+CTRL_W-1:0] skid_dout;

  pipe_skid_buf #(
    .W(DATA_W + CTRL_W)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .flush(bus.flush),
    .push (skid_push),
    .pop  (skid_pop),
    .din  ({bus.in_data, bus.in_ctrl}),
    .dout (skid_dout),
    .valid(skid_valid)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) state_nxt = ST_FULL;
        end
        ST_FULL: begin
`ifdef PIPE_SKID_EN
          if (in_xfer && !bus.out_ready) state_nxt = ST_SKID;
          else if (out_xfer && !in_xfer) state_nxt = ST_EMPTY;
`else
          if (out_xfer && !in_xfer) state_nxt = ST_EMPTY;
`endif
        end
        ST_SKID: begin
          if (out_xfer) state_nxt = ST_FULL;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_int = (state != ST_EMPTY);
`ifdef PIPE_SKID_EN
    // Registered ready: depends only on the skid flop, never on out_ready
    in_ready_int  = !skid_valid;
`else
    in_ready_int  = !out_valid_int || bus.out_ready;
`endif
    in_xfer  = bus.in_valid && in_ready_int;
    out_xfer = out_valid_int && bus.out_ready;
    // New item goes straight to the main register unless it must be parked
    load_in  = in_xfer && !bus.flush && ((state == ST_EMPTY) || bus.out_ready);
`ifdef PIPE_SKID_EN
    skid_push = (state == ST_FULL) && in_xfer && !bus.out_ready && !bus.flush;
    skid_pop  = (state == ST_SKID) && out_xfer && !bus.flush;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (bus.flush) begin
      main_ctrl <= '0;
`ifdef PIPE_SKID_EN
    end else if (skid_pop) begin
      {main_data, main_ctrl} <= skid_dout;
`endif
    end else if (load_in) begin
      main_data <= bus.in_data;
      main_ctrl <= bus.in_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid_int && !bus.out_ready && !bus.flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = main_data;
  // Gate control so a bubble can never assert write_reg or a memory access
  assign bus.out_ctrl  = out_valid_int ? main_ctrl : CTRL_W'(CTRL_NOP);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the reference is an ordered queue of held items
// (capacity 1, or 2 with PIPE_SKID_EN) plus a saturating stall count.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam int NW = 4;
  localparam int SAT = (1 << NW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } item_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] stall_cnt;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_stall = 0;
  int    pops = 0;
  bit    mon_en = 1'b0;
  bit    mon_ov;
  bit    mon_ir;
  item_t mon_e;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares at the falling edge, then advances the model to the next rising edge
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon_ov = (sb.size() != 0);
`ifdef PIPE_SKID_EN
      mon_ir = (sb.size() < 2);
`else
      mon_ir = (sb.size() == 0) || bus.out_ready;
`endif
      chk("out_valid", bus.out_valid, mon_ov);
      chk("in_ready", bus.in_ready, mon_ir);
      if (!bus.out_valid) chk("out_ctrl_bubble", bus.out_ctrl, 0);
      chk("stall_cnt", stall_cnt, exp_stall);
      if (bus.flush) begin
        sb.delete();
      end else if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", bus.out_data);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", bus.out_data, mon_e.data);
          chk("out_ctrl", bus.out_ctrl, mon_e.ctrl);
          pops++;
        end
      end
      if (mon_ov && !bus.out_ready && !bus.flush && exp_stall < SAT) exp_stall++;
    end
  end

  // One clock of stimulus, entered and left at posedge+1
  task automatic step(bit iv, logic [DW-1:0] d, logic [CW-1:0] c, bit ordy, bit fl);
    bit acc;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(negedge clk);
    acc = iv && bus.in_ready && !fl;
    @(posedge clk);
    if (acc) sb.push_back(item_t'{data: d, ctrl: c});
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ctrl", bus.out_ctrl, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    sb.delete();
    exp_stall = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    #1;
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_out_data", bus.out_data, 0);
    chk("init_out_ctrl", bus.out_ctrl, 0);
    chk("init_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("idle_in_ready", bus.in_ready, 1);

    // Reset mid-stream with an item held and stalled
    for (int i = 0; i < 3; i++) step(1'b1, 64'hDEAD_BEEF_0000_0001, 4'b0100, 1'b0, 1'b0);
    do_reset();

    // Streaming
    p0 = pops;
    for (int i = 0; i < 8; i++) step(1'b1, 64'(i), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stream_count", 64'(pops - p0), 8);

    // Stall with item A held for 5 cycles
    do_reset();
    step(1'b1, 64'hA, 4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 64'hB, 4'b0001, 1'b0, 1'b0);
    chk("stall_5", stall_cnt, 5);
    chk("stall_hold", bus.out_data, 64'hA);
    p0 = pops;
    drain();
    chk("stall_delivered", 64'(pops - p0) != 0, 1);

    // Flush kills held item and the same-cycle input
    step(1'b1, 64'h11, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 64'h22, 4'b0010, 1'b1, 1'b1);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_out_ctrl", bus.out_ctrl, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Saturation of stall counter
    do_reset();
    step(1'b1, 64'h55, 4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_15", stall_cnt, 15);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_hold", stall_cnt, 15);
    drain();

`ifdef PIPE_SKID_EN
    // Skid: B parks while A is stalled, then A and B leave in order
    do_reset();
    step(1'b1, 64'hA0, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 64'hB0, 4'b0010, 1'b0, 1'b0);
    chk("skid_in_ready", bus.in_ready, 0);
    p0 = pops;
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("skid_pair", 64'(pops - p0), 2);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    drain();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
